ro_freq_meter: RTL and testbench

Measures the frequency of a free-running LUT ring oscillator from the board clock domain. The oscillator output first goes through a small prescaler that runs in the oscillator's own domain. The divided signal is synchronized into ICE_CLK, and its rising edges are counted over a fixed gate window of ICE_CLK cycles. The result is presented with a start/valid handshake for use by PUF-response logic or the UART/LED debug path.

---
 rtl/ro_freq_meter_pkg.sv | 18 +
 rtl/ro_freq_meter_if.sv | 34 +++
 rtl/ro_freq_meter_prescaler.sv | 32 +++
 rtl/ro_freq_meter.sv | 157 +++++++++++++++
 tb/tb_ro_freq_meter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_freq_meter_pkg.sv
// rtl/ro_freq_meter_pkg.sv - shared state encodings and defaults for the ring-oscillator frequency meter
//
// Contents:
//   meter_state_e       - measurement FSM states, also decoded by the PUF comparator
//   DEFAULT_GATE_CYCLES - gate window in ICE_CLK cycles (1 ms at 12 MHz)
`timescale 1ns/1ps
package ro_freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } meter_state_e;

    localparam int DEFAULT_GATE_CYCLES = 12000;

endpackage

// File: rtl/ro_freq_meter_if.sv
// rtl/ro_freq_meter_if.sv - start/result handshake bundle between a requester and the frequency meter
//
// Signals:
//   start       - single-cycle measurement request (requester -> meter)
//   busy        - measurement in progress
//   count_valid - count/overflow hold a completed result
//   count       - divided-oscillator rising edges seen during the gate window
//   overflow    - count saturated during the last measurement
`timescale 1ns/1ps
interface ro_freq_meter_if #(
    parameter int COUNT_W = 16
);
    logic               start;
    logic               busy;
    logic               count_valid;
    logic [COUNT_W-1:0] count;
    logic               overflow;

    modport master (
        output start,
        input  busy,
        input  count_valid,
        input  count,
        input  overflow
    );

    modport slave (
        input  start,
        output busy,
        output count_valid,
        output count,
        output overflow
    );
endinterface

// File: rtl/ro_freq_meter_prescaler.sv
// rtl/ro_freq_meter_prescaler.sv - oscillator-domain divider, ro_div = f_ro / 2^(PRESCALE_LOG2+1)
//
// Ports:
//   ro_clk - raw ring oscillator output, used as this module's clock
//   rst_n  - asynchronous active-low reset
//   ro_div - divided oscillator (counter MSB), the only signal leaving this domain
`timescale 1ns/1ps
module ro_prescaler #(
    parameter int PRESCALE_LOG2 = 4
) (
    input  logic ro_clk,
    input  logic rst_n,
    output logic ro_div
);
    localparam int DIV_W = PRESCALE_LOG2 + 1;

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign div_cnt_d = div_cnt_q + DIV_W'(1);

    always_ff @(posedge ro_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Taken straight from a flop so the crossing carries a glitch-free square wave.
    assign ro_div = div_cnt_q[PRESCALE_LOG2];
endmodule

// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - gated edge counter measuring a ring oscillator from the ICE_CLK domain
//
// Ports:
//   ICE_CLK - system clock
//   rst_n   - asynchronous active-low reset for both clock domains
//   ro_clk  - raw ring oscillator output
//   bus     - slave side of ro_freq_meter_if (start, busy, count_valid, count, overflow)
`timescale 1ns/1ps
module ro_freq_meter
    import ro_freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES   = DEFAULT_GATE_CYCLES,
    parameter int PRESCALE_LOG2 = 4,
    parameter int COUNT_W       = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic           ICE_CLK,
    input  logic           rst_n,
    input  logic           ro_clk,
    ro_freq_meter_if.slave bus
);
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int ARM_W  = $clog2(SYNC_STAGES + 1);

    localparam logic [COUNT_W-1:0] ACC_MAX   = '1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(SYNC_STAGES - 1);

    logic ro_div;

    ro_prescaler #(
        .PRESCALE_LOG2 (PRESCALE_LOG2)
    ) u_prescaler (
        .ro_clk (ro_clk),
        .rst_n  (rst_n),
        .ro_div (ro_div)
    );

    // ro_div is the only signal crossing into ICE_CLK; the history flop sits
    // behind the last synchronizer stage so edge detection never sees a
    // possibly metastable value.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   ro_edge;

    always_ff @(posedge ICE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_div};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ro_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

    meter_state_e       state_q,    state_d;
    logic [ARM_W-1:0]   arm_cnt_q,  arm_cnt_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [COUNT_W-1:0] acc_q,      acc_d;
    logic               sat_q,      sat_d;
    logic               busy_q,     busy_d;
    logic               valid_q,    valid_d;
    logic [COUNT_W-1:0] count_q,    count_d;
    logic               ovf_q,      ovf_d;

    always_ff @(posedge ICE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            arm_cnt_q  <= '0;
            gate_cnt_q <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        gate_cnt_d = gate_cnt_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // start is only looked at here, so a request while busy is dropped.
                if (bus.start) begin
                    state_d   = ST_ARM;
                    arm_cnt_d = '0;
                    acc_d     = '0;
                    sat_d     = 1'b0;
                    valid_d   = 1'b0;
                    ovf_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_ARM: begin
                // Let edges already in flight through the synchronizer drain
                // so the window only counts edges arriving after start.
                if (arm_cnt_q == ARM_LAST) begin
                    state_d    = ST_GATE;
                    gate_cnt_d = '0;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_GATE: begin
                if (ro_edge) begin
                    if (acc_q == ACC_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        acc_d = acc_q + COUNT_W'(1);
                    end
                end
                if (gate_cnt_q == GATE_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                end
            end
            ST_DONE: begin
                count_d = acc_q;
                ovf_d   = sat_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.count_valid = valid_q;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - self-checking bench for ro_freq_meter
`timescale 1ns/1ps
module tb_ro_freq_meter;
    localparam int  GATE    = 100;
    localparam int  PLOG    = 0;
    localparam int  SYNC    = 2;
    localparam int  W_BIG   = 16;
    localparam int  W_SMALL = 3;
    localparam int  LAT     = SYNC + GATE + 1;
    localparam int  DIV     = 2 ** (PLOG + 1);
    localparam real CLK_P   = 10.0;

    logic ICE_CLK = 1'b0;
    logic rst_n   = 1'b0;
    logic ro_clk  = 1'b0;

    ro_freq_meter_if #(.COUNT_W(W_BIG))   bus   ();
    ro_freq_meter_if #(.COUNT_W(W_SMALL)) bus_s ();

    ro_freq_meter #(
        .GATE_CYCLES (GATE), .PRESCALE_LOG2 (PLOG), .COUNT_W (W_BIG), .SYNC_STAGES (SYNC)
    ) dut (
        .ICE_CLK (ICE_CLK), .rst_n (rst_n), .ro_clk (ro_clk), .bus (bus)
    );

    ro_freq_meter #(
        .GATE_CYCLES (GATE), .PRESCALE_LOG2 (PLOG), .COUNT_W (W_SMALL), .SYNC_STAGES (SYNC)
    ) dut_s (
        .ICE_CLK (ICE_CLK), .rst_n (rst_n), .ro_clk (ro_clk), .bus (bus_s)
    );

    always #5 ICE_CLK = ~ICE_CLK;

    real ro_half = 20.0;
    bit  ro_en   = 1'b0;

    initial begin
        #2;
        forever begin
            if (ro_en) begin
                #(ro_half) ro_clk = ~ro_clk;
            end else begin
                ro_clk = 1'b0;
                #1;
            end
        end
    end

    // Reference model: the n-th oscillator rising edge after reset makes the
    // divided clock rise whenever n mod DIV == DIV/2. A rise at time t is
    // counted when it lands in [t_start, t_start + GATE*CLK_P), t_start being
    // the clock edge that accepted start.
    int  ro_pos_n;
    real rise_q[$];

    always @(posedge ro_clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_pos_n = 0;
            rise_q.delete();
        end else begin
            ro_pos_n++;
            if (ro_pos_n % DIV == DIV / 2) rise_q.push_back($realtime);
        end
    end

    function automatic int model_count(input real t0);
        int n = 0;
        foreach (rise_q[i]) begin
            if (rise_q[i] >= t0 && rise_q[i] < t0 + GATE * CLK_P) n++;
        end
        return n;
    endfunction

    int both_hits = 0;
    always @(negedge ICE_CLK) begin
        if (bus.busy && bus.count_valid) both_hits++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_start(input bit v);
        bus.start   = v;
        bus_s.start = v;
    endtask

    // Pulses start, then samples at each falling edge until count_valid rises.
    // lat is the number of clock edges after the accepting edge (-1 on timeout).
    task automatic measure(input bit poke, output int lat, output int gaps, output real tk);
        int idx;
        lat  = -1;
        gaps = 0;
        idx  = 0;
        @(negedge ICE_CLK);
        drive_start(1'b1);
        @(posedge ICE_CLK);
        tk = $realtime;
        @(negedge ICE_CLK);
        drive_start(1'b0);
        while (idx <= LAT + 20) begin
            if (bus.count_valid) begin
                lat = idx;
                break;
            end
            if (!bus.busy) gaps++;
            drive_start(poke && (idx == 10 || idx == 50));
            @(negedge ICE_CLK);
            idx++;
        end
        drive_start(1'b0);
    endtask

    typedef struct {
        bit  ro_on;
        real half;
        int  lo;
        int  hi;
        int  s_cnt;
        int  s_ovf;
    } vec_t;

    vec_t vecs[4];

    task automatic check_result(input string tag, input real tk, input int lat, input int gaps);
        int m;
        m = model_count(tk);
        check({tag, "_latency"}, lat, LAT, LAT);
        check({tag, "_busy_gap"}, gaps, 0, 0);
        check({tag, "_busy_done"}, int'(bus.busy), 0, 0);
        check({tag, "_cnt_model"}, int'(bus.count), m - 1, m + 1);
        check({tag, "_ovf"}, int'(bus.overflow), 0, 0);
    endtask

    initial begin
        int  lat, gaps, held, m;
        real tk;

        drive_start(1'b0);
        vecs[0] = '{1'b0, 20.0,  0,  0, 0, 0};
        vecs[1] = '{1'b1, 20.0, 12, 13, 7, 1};
        vecs[2] = '{1'b1, 10.0, 24, 26, 7, 1};
        vecs[3] = '{1'b1, 15.0, 16, 17, 7, 1};

        rst_n = 1'b0;
        repeat (3) @(negedge ICE_CLK);
        check("rst_busy",  int'(bus.busy), 0, 0);
        check("rst_valid", int'(bus.count_valid), 0, 0);
        check("rst_count", int'(bus.count), 0, 0);
        check("rst_ovf",   int'(bus.overflow), 0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge ICE_CLK);

        // Table: oscillator off, 40 ns, 20 ns, 30 ns; small instance saturates.
        foreach (vecs[i]) begin
            ro_half = vecs[i].half;
            ro_en   = vecs[i].ro_on;
            repeat (5) @(negedge ICE_CLK);
            measure(1'b0, lat, gaps, tk);
            check_result($sformatf("vec%0d", i), tk, lat, gaps);
            check($sformatf("vec%0d_cnt_range", i), int'(bus.count), vecs[i].lo, vecs[i].hi);
            check($sformatf("vec%0d_small_cnt", i), int'(bus_s.count), vecs[i].s_cnt, vecs[i].s_cnt);
            check($sformatf("vec%0d_small_ovf", i), int'(bus_s.overflow), vecs[i].s_ovf, vecs[i].s_ovf);
            check($sformatf("vec%0d_busy_and_valid", i), both_hits, 0, 0);
        end

        // Result holds while idle.
        held = int'(bus.count);
        repeat (20) @(negedge ICE_CLK);
        check("hold_count", int'(bus.count), held, held);
        check("hold_valid", int'(bus.count_valid), 1, 1);

        // Starts during a measurement are ignored; a new start clears count_valid.
        ro_half = 20.0;
        ro_en   = 1'b1;
        repeat (5) @(negedge ICE_CLK);
        measure(1'b1, lat, gaps, tk);
        check_result("restart", tk, lat, gaps);
        drive_start(1'b1);
        @(posedge ICE_CLK);
        @(negedge ICE_CLK);
        drive_start(1'b0);
        check("restart_valid_clr", int'(bus.count_valid), 0, 0);
        check("restart_busy_set",  int'(bus.busy), 1, 1);
        for (int j = 0; j < LAT + 20 && !bus.count_valid; j++) @(negedge ICE_CLK);
        check("restart_second_done", int'(bus.count_valid), 1, 1);

        // Asynchronous reset 40 cycles into the gate window.
        @(negedge ICE_CLK);
        drive_start(1'b1);
        @(posedge ICE_CLK);
        @(negedge ICE_CLK);
        drive_start(1'b0);
        repeat (SYNC + 40) @(negedge ICE_CLK);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",  int'(bus.busy), 0, 0);
        check("midrst_valid", int'(bus.count_valid), 0, 0);
        check("midrst_count", int'(bus.count), 0, 0);
        check("midrst_ovf",   int'(bus.overflow), 0, 0);
        check("midrst_small_count", int'(bus_s.count), 0, 0);
        @(negedge ICE_CLK);
        rst_n = 1'b1;
        repeat (SYNC + GATE + 5) @(negedge ICE_CLK);
        check("midrst_no_partial", int'(bus.count_valid), 0, 0);
        measure(1'b0, lat, gaps, tk);
        check_result("after_rst", tk, lat, gaps);

        // Randomised oscillator periods against the model.
        for (int r = 0; r < 6; r++) begin
            ro_half = real'($urandom_range(60, 400)) / 10.0;
            repeat (5) @(negedge ICE_CLK);
            measure(1'b0, lat, gaps, tk);
            check_result($sformatf("rand%0d", r), tk, lat, gaps);
            m = model_count(tk);
            if (m >= 9) begin
                check($sformatf("rand%0d_small_sat", r), int'(bus_s.count), 7, 7);
                check($sformatf("rand%0d_small_ovf", r), int'(bus_s.overflow), 1, 1);
            end else if (m <= 6) begin
                check($sformatf("rand%0d_small_cnt", r), int'(bus_s.count), m - 1, m + 1);
                check($sformatf("rand%0d_small_ovf", r), int'(bus_s.overflow), 0, 0);
            end
        end
        check("busy_and_valid_total", both_hits, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
